// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional DIV_SELFCHECK_EN adds a sticky chk_err from a multiply-back check.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
`ifdef DIV_SELFCHECK_EN
  output logic             chk_err,
`endif
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             bzero;
  logic             last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  assign accept = start && (state != RUN);
  assign bzero  = (b == '0);
  assign last   = (cnt == '0);

  // dvd doubles as the quotient shift register: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    shifted  = {prem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    qbit     = ~trial[WIDTH];
    prem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = bzero ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = bzero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      dvs  <= '0;
      prem <= '0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
    end else if (accept) begin
      if (bzero) begin
        quo <= '1;
        rem <= a;
        dbz <= 1'b1;
      end else begin
        dvd  <= a;
        dvs  <= b;
        prem <= '0;
        cnt  <= CW'(WIDTH - 1);
        dbz  <= 1'b0;
      end
    end else if (state == RUN) begin
      prem <= prem_nxt;
      dvd  <= dvd_nxt;
      if (last) begin
        quo <= dvd_nxt;
        rem <= prem_nxt;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef DIV_SELFCHECK_EN
  logic [WIDTH-1:0]   a_l;
  logic [2*WIDTH-1:0] recon;

  always_comb begin
    recon = {{WIDTH{1'b0}}, quo} * {{WIDTH{1'b0}}, dvs}
          + {{WIDTH{1'b0}}, rem};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_l     <= '0;
      chk_err <= 1'b0;
    end else begin
      if (accept) a_l <= a;
      if (state == DONE && !dbz
          && recon != {{WIDTH{1'b0}}, a_l})
        chk_err <= 1'b1;
    end
  end
`endif

endmodule
